imem_loader: RTL

//  Writer side of the 19-bit instruction memory port. The pipeline's fetch stage only reads this memory.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by imem_loader and its host.
// The slave modport is the loader side; the master modport is the host/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 19
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream of 3-byte instructions into instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INST_W     = 19,
  parameter int unsigned START_ADDR = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  imem_loader_if.slave io_bus,
  output logic         o_cpu_reset,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);
  localparam int unsigned       HI_W  = INST_W - 16;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    StIdle, StLen, StB0, StB1, StB2, StWrite, StChk, StDone
  } state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cnt;
  logic [HI_W-1:0]   r_hi;
  logic [7:0]        r_mid;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [INST_W-1:0] r_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_accept;
  logic w_start_ok;

  assign io_bus.s_ready = (r_state == StLen) || (r_state == StB0) || (r_state == StB1) ||
                          (r_state == StB2)  || (r_state == StChk);
  assign w_accept   = io_bus.s_valid && io_bus.s_ready;
  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       w_chk_bad;

  // Running XOR of every accepted byte; including the checksum byte the total must be zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_xor <= 8'h00;
    end else if (w_start_ok) begin
      r_xor <= 8'h00;
    end else if (w_accept) begin
      r_xor <= r_xor ^ io_bus.s_data;
    end
  end

  assign w_chk_bad = (r_xor ^ io_bus.s_data) != 8'h00;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_addr      <= START;
      r_cnt       <= 8'd0;
      r_hi        <= '0;
      r_mid       <= 8'd0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state     <= StLen;
            r_err       <= 1'b0;
            r_addr      <= START;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        StLen: begin
          if (w_accept) begin
            r_cnt <= io_bus.s_data;
            if (io_bus.s_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= StChk;
`else
              r_state     <= StDone;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_reset <= r_err;
`endif
            end else begin
              r_state <= StB0;
            end
          end
        end
        StB0: begin
          if (w_accept) begin
            r_hi <= io_bus.s_data[HI_W-1:0];
            // Bits above the instruction width flag a malformed stream but the byte is consumed.
            if (|(io_bus.s_data >> HI_W)) begin
              r_err <= 1'b1;
            end
            r_state <= StB1;
          end
        end
        StB1: begin
          if (w_accept) begin
            r_mid   <= io_bus.s_data;
            r_state <= StB2;
          end
        end
        StB2: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= {r_hi, r_mid, io_bus.s_data};
            r_state <= StWrite;
          end
        end
        StWrite: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= StChk;
`else
            r_state     <= StDone;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_reset <= r_err;
`endif
          end else begin
            r_state <= StB0;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (w_accept) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (w_chk_bad) begin
              r_err       <= 1'b1;
              r_cpu_reset <= 1'b1;
            end else begin
              r_cpu_reset <= r_err;
            end
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.imem_we    = r_we;
  assign io_bus.imem_addr  = r_waddr;
  assign io_bus.imem_wdata = r_wdata;
  assign o_cpu_reset       = r_cpu_reset;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_err             = r_err;
endmodule
